// File: rtl/mealy_seq_detector_if.sv
// Serial detector port bundle: sampler side drives en/clear/w, status side reads z, z_q, fill and count.
interface mealy_seq_detector_if #(
  parameter int PATTERN_LEN = 3,
  parameter int COUNT_W     = 8
);
  localparam int FILL_W = $clog2(PATTERN_LEN);

  logic               en;
  logic               clear;
  logic               w;
  logic               z;
  logic               z_q;
  logic [FILL_W-1:0]  fill;
  logic [COUNT_W-1:0] count;

  modport master (output en, clear, w, input z, z_q, fill, count);
  modport slave  (input en, clear, w, output z, z_q, fill, count);
endinterface

// File: rtl/mealy_seq_detector.sv
// Parametrised serial Mealy pattern detector with combinational and registered match
// outputs, history fill level and a saturating match counter.
module mealy_seq_detector #(
  parameter int                     PATTERN_LEN = 3,
  parameter logic [PATTERN_LEN-1:0] PATTERN     = 3'b101,
  parameter bit                     OVERLAP     = 1'b1,
  parameter int                     COUNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  mealy_seq_detector_if.slave  bus
);
  localparam int HW = PATTERN_LEN - 1;
  localparam int FW = $clog2(PATTERN_LEN);

  logic [HW-1:0]          hist;
  logic [FW-1:0]          fill_r;
  logic [COUNT_W-1:0]     cnt_r;
  logic                   zq_r;
  logic [PATTERN_LEN-1:0] cand;
  logic                   full;
  logic                   match;

  // hist[0] is the most recently accepted bit, so the incoming bit lands at the LSB
  assign cand  = {hist, bus.w};
  assign full  = (fill_r == FW'(HW));
  assign match = bus.en & ~bus.clear & full & (cand == PATTERN);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hist   <= '0;
      fill_r <= '0;
      cnt_r  <= '0;
      zq_r   <= 1'b0;
    end else begin
      zq_r <= match;
      if (bus.clear) begin
        hist   <= '0;
        fill_r <= '0;
        cnt_r  <= '0;
      end else if (bus.en) begin
        // non-overlapping mode restarts the search from an empty history
        if (match && !OVERLAP) begin
          hist   <= '0;
          fill_r <= '0;
        end else begin
          hist <= cand[HW-1:0];
          if (!full) fill_r <= fill_r + 1'b1;
        end
        if (match && (cnt_r != '1)) cnt_r <= cnt_r + 1'b1;
      end
    end
  end

  assign bus.z     = match;
  assign bus.z_q   = zq_r;
  assign bus.fill  = fill_r;
  assign bus.count = cnt_r;
endmodule

// File: tb/tb_mealy_seq_detector.sv
// Bench for mealy_seq_detector: three instances (overlap, non-overlap, 2-bit counter)
// share one stimulus stream and are checked against a reference model via a scoreboard.
`timescale 1ns/1ps
module tb_mealy_seq_detector;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic en = 1'b0, clear = 1'b0, w = 1'b0;

  always #5 clk = ~clk;

  mealy_seq_detector_if #(.PATTERN_LEN(3), .COUNT_W(8)) if0 ();
  mealy_seq_detector_if #(.PATTERN_LEN(3), .COUNT_W(8)) if1 ();
  mealy_seq_detector_if #(.PATTERN_LEN(3), .COUNT_W(2)) if2 ();

  assign if0.en = en;  assign if0.clear = clear;  assign if0.w = w;
  assign if1.en = en;  assign if1.clear = clear;  assign if1.w = w;
  assign if2.en = en;  assign if2.clear = clear;  assign if2.w = w;

  mealy_seq_detector #(.PATTERN_LEN(3), .PATTERN(3'b101), .OVERLAP(1'b1), .COUNT_W(8))
    u_ovl (.clk(clk), .reset_n(reset_n), .bus(if0));
  mealy_seq_detector #(.PATTERN_LEN(3), .PATTERN(3'b101), .OVERLAP(1'b0), .COUNT_W(8))
    u_nov (.clk(clk), .reset_n(reset_n), .bus(if1));
  mealy_seq_detector #(.PATTERN_LEN(3), .PATTERN(3'b101), .OVERLAP(1'b1), .COUNT_W(2))
    u_sat (.clk(clk), .reset_n(reset_n), .bus(if2));

  logic       z_a  [3];
  logic       zq_a [3];
  logic [1:0] fl_a [3];
  logic [7:0] cn_a [3];
  assign z_a[0] = if0.z;  assign zq_a[0] = if0.z_q;  assign fl_a[0] = if0.fill;  assign cn_a[0] = if0.count;
  assign z_a[1] = if1.z;  assign zq_a[1] = if1.z_q;  assign fl_a[1] = if1.fill;  assign cn_a[1] = if1.count;
  assign z_a[2] = if2.z;  assign zq_a[2] = if2.z_q;  assign fl_a[2] = if2.fill;  assign cn_a[2] = {6'b0, if2.count};

  // reference model state per instance
  int   m_ovl  [3] = '{1, 0, 1};
  int   m_cmax [3] = '{255, 255, 3};
  logic [1:0] m_hist [3];
  int   m_fill [3];
  int   m_cnt  [3];

  typedef struct { int d; int zq; int fill; int cnt; } exp_t;
  exp_t sb[$];

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      m_hist[d] = 2'b00; m_fill[d] = 0; m_cnt[d] = 0;
    end
    sb.delete();
  endtask

  // one sample cycle; ez0/ez1 are optional directed z expectations for u_ovl/u_nov
  task automatic cyc(input logic e, input logic c, input logic wv,
                     input int ez0 = -1, input int ez1 = -1);
    @(negedge clk);
    en = e; clear = c; w = wv;
    #1;
    for (int d = 0; d < 3; d++) begin
      int   m;
      exp_t x;
      m = (e && !c && m_fill[d] == 2 && {m_hist[d], wv} == 3'b101) ? 1 : 0;
      chk($sformatf("z[%0d]", d), int'(z_a[d]), m);
      if (c) begin
        m_hist[d] = 2'b00; m_fill[d] = 0; m_cnt[d] = 0;
      end else if (e) begin
        if (m == 1 && m_ovl[d] == 0) begin
          m_hist[d] = 2'b00; m_fill[d] = 0;
        end else begin
          m_hist[d] = {m_hist[d][0], wv};
          if (m_fill[d] < 2) m_fill[d]++;
        end
        if (m == 1 && m_cnt[d] < m_cmax[d]) m_cnt[d]++;
      end
      x.d = d; x.zq = m; x.fill = m_fill[d]; x.cnt = m_cnt[d];
      sb.push_back(x);
    end
    if (ez0 >= 0) chk("z_dir_ovl", int'(z_a[0]), ez0);
    if (ez1 >= 0) chk("z_dir_nov", int'(z_a[1]), ez1);
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      exp_t x;
      x = sb.pop_front();
      chk($sformatf("z_q[%0d]", x.d),   int'(zq_a[x.d]), x.zq);
      chk($sformatf("fill[%0d]", x.d),  int'(fl_a[x.d]), x.fill);
      chk($sformatf("count[%0d]", x.d), int'(cn_a[x.d]), x.cnt);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    model_reset();
    // reset held with activity on the inputs
    en = 1'b1; w = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("rst_z[%0d]", d),     int'(z_a[d]),  0);
      chk($sformatf("rst_zq[%0d]", d),    int'(zq_a[d]), 0);
      chk($sformatf("rst_fill[%0d]", d),  int'(fl_a[d]), 0);
      chk($sformatf("rst_count[%0d]", d), int'(cn_a[d]), 0);
    end
    @(negedge clk);
    en = 1'b0; reset_n = 1'b1;

    // 1,0,1,0,1: overlap hits on 3 and 5, non-overlap only on 3
    cyc(1, 0, 1, 0, 0);
    chk("fill_after_1", int'(fl_a[0]), 1);
    cyc(1, 0, 0, 0, 0);
    chk("fill_after_2", int'(fl_a[0]), 2);
    cyc(1, 0, 1, 1, 1);
    cyc(1, 0, 0, 0, 0);
    chk("zq_cycle4", int'(zq_a[0]), 0);
    cyc(1, 0, 1, 1, 0);
    chk("ovl_count", int'(cn_a[0]), 2);
    chk("nov_count", int'(cn_a[1]), 1);
    cyc(0, 0, 0, 0, 0);
    chk("zq_cycle6", int'(zq_a[0]), 0);

    // non-overlap after clear: 1,0,1,1,0,1 hits on 3 and 6
    cyc(1, 1, 0);
    cyc(1, 0, 1, -1, 0);
    cyc(1, 0, 0, -1, 0);
    cyc(1, 0, 1, -1, 1);
    cyc(1, 0, 1, -1, 0);
    cyc(1, 0, 0, -1, 0);
    cyc(1, 0, 1, -1, 1);
    chk("nov_count2", int'(cn_a[1]), 2);

    // enable gap: pattern spans disabled cycles
    cyc(1, 1, 0);
    cyc(1, 0, 1, 0);
    cyc(1, 0, 0, 0);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 0);
    cyc(1, 0, 1, 1);
    chk("gap_count", int'(cn_a[0]), 1);

    // async reset mid-pattern
    cyc(1, 0, 0);
    #1 reset_n = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("arst_fill[%0d]", d),  int'(fl_a[d]), 0);
      chk($sformatf("arst_count[%0d]", d), int'(cn_a[d]), 0);
      chk($sformatf("arst_zq[%0d]", d),    int'(zq_a[d]), 0);
    end
    model_reset();
    #1 reset_n = 1'b1;
    cyc(1, 0, 1, 0, 0);
    chk("arst_fill_after", int'(fl_a[0]), 1);

    // saturation: five overlapping matches on a 2-bit counter
    cyc(1, 1, 0);
    for (int i = 0; i < 11; i++) cyc(1, 0, (i % 2 == 0) ? 1'b1 : 1'b0);
    chk("sat_count", int'(cn_a[2]), 3);
    chk("ovl_count5", int'(cn_a[0]), 5);
    cyc(1, 0, 0);
    // clear wins over a completing bit
    cyc(1, 1, 1, 0, 0);
    chk("clr_count", int'(cn_a[2]), 0);
    chk("clr_fill", int'(fl_a[2]), 0);
    chk("clr_zq", int'(zq_a[2]), 0);

    // random tail against the model
    for (int i = 0; i < 200; i++)
      cyc(($urandom_range(0, 3) != 0), ($urandom_range(0, 31) == 0), $urandom_range(0, 1));

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/mealy_seq_detector.md
Name: mealy_seq_detector

Overview:
- Parametrised serial Mealy sequence detector. It is the successor to the fixed 2-state-bit Mealy machine, whose output logic is z = f(w, y1, y2).
- Compares the serial input w against a PATTERN_LEN-bit pattern fixed at elaboration, with selectable overlapping or non-overlapping detection.
- Provides a combinational Mealy output, a registered copy of it, and a saturating match counter.
- Sits between the serial input sampler and the status/interrupt logic.

Parameters:
- PATTERN_LEN, 3, pattern length in bits; legal range 2..16.
- PATTERN, 3'b101, pattern value; bit PATTERN_LEN-1 is the first bit received.
- OVERLAP, 1, 1 = overlapping detection, 0 = non-overlapping detection.
- COUNT_W, 8, width of the match counter.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- en  in  1  sample enable; w is consumed only on cycles where en=1.
- clear  in  1  synchronous clear of history, fill level, counter and z_q.
- w  in  1  serial data input.
- z  out  1  Mealy output (combinational); high in the same cycle as the completing bit.
- z_q  out  1  z registered; one cycle after z.
- fill  out  clog2(PATTERN_LEN)  number of valid history bits, saturating at PATTERN_LEN-1.
- count  out  COUNT_W  number of matches, saturating.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - Internal history register hist (PATTERN_LEN-1 bits) is cleared to 0.
  - fill=0, count=0, z_q=0.
  - z=0 while reset is held.
- Candidate word: cand = {hist, w}, where hist[0] is the most recent accepted bit.
- Match condition: match = en & ~clear & (fill == PATTERN_LEN-1) & (cand == PATTERN).
- Output z = match. z is purely combinational from w, en, clear and state, with no added latency.
- On a clock edge with en=1 and clear=0:
  - If not match, or match with OVERLAP=1: hist <= cand[PATTERN_LEN-2:0]; fill <= min(fill+1, PATTERN_LEN-1).
  - If match with OVERLAP=0: hist <= 0; fill <= 0.
  - If match: count <= count+1, held at 2^COUNT_W-1 once reached.
- On a clock edge with en=0 and clear=0:
  - hist, fill and count hold.
  - z=0.
- z_q <= match on every edge; z_q <= 0 when clear=1.
- clear=1 has priority over en and over a simultaneous match:
  - State goes to the reset values.
  - The match is not counted.
  - z=0 in that cycle.
- fill gates detection: no z until PATTERN_LEN bits have been accepted since reset, clear, or a non-overlap match.
- Reset asserted mid-pattern discards any partial match immediately. The first bit accepted after release starts a new pattern.
- Bits with en=0 are ignored entirely: no gap detection, and the pattern may span disabled cycles.

Test Plan (defaults unless stated; cycle n = nth cycle with en=1):
- Reset: reset_n=0 with arbitrary w/en -> z=0, z_q=0, fill=0, count=0; fill increments 1 per accepted bit after release.
- Overlap: OVERLAP=1, w=1,0,1,0,1 -> z=1 in cycles 3 and 5 only; z_q=1 in cycles 4 and 6; count=2.
- Non-overlap: OVERLAP=0, w=1,0,1,0,1 -> z=1 in cycle 3 only, count=1. Then w=1,0,1,1,0,1 after clear -> z=1 in cycles 3 and 6, count=2.
- Enable gap: w=1,0, then en=0 for 3 cycles with w=1, then en=1 with w=1 -> z=0 during the gap; z=1 on the first re-enabled cycle; count=1.
- Saturation/clear: COUNT_W=2, 5 overlapping matches -> count stays 3. Then clear=1 in the same cycle as a completing bit -> z=0, count=0, fill=0.
- Async reset mid-pattern: w=1,0, then reset_n pulsed low between edges -> fill, count and z_q are 0 immediately without a clock edge. Then w=1 -> z=0 and fill=1.
